// File: rtl/id_counter.sv
// rtl/id_counter.sv - DPLL increment/decrement counter: DCO with rate-limited phase advance/retard.
// Optional IDC_SYNC_EN puts a two-flop synchronizer on incIn/decIn ahead of edge detection.
module id_counter #(
  parameter int DIV_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic incIn,
  input  logic decIn,
  output logic inc,
  output logic dec,
  output logic incIgnore,
  output logic decIgnore,
  output logic IDout
);

  localparam int CW = $clog2(DIV_HALF + 2);
  localparam int LW = $clog2(DIV_HALF + 1);
  localparam logic [CW-1:0] DIV_C     = CW'(DIV_HALF);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(DIV_HALF);

  // bit 0 = increment path, bit 1 = decrement path
  logic [1:0] lvl_q;
  logic [1:0] prev_q;

`ifdef IDC_SYNC_EN
  logic [1:0] meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      lvl_q  <= '0;
    end else begin
      meta_q <= {decIn, incIn};
      lvl_q  <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= {decIn, incIn};
    end
  end
`endif

  logic [LW-1:0] inc_lock_q, inc_lock_d;
  logic [LW-1:0] dec_lock_q, dec_lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic          inc_q, dec_q, inc_ign_q, dec_ign_q;

  logic [1:0]    ev;
  logic          inc_acc, dec_acc, inc_ign, dec_ign;
  logic [CW-1:0] step;
  logic [CW-1:0] sum;

  always_comb begin
    ev      = lvl_q & ~prev_q;
    inc_acc = ev[0] && (inc_lock_q == '0);
    dec_acc = ev[1] && (dec_lock_q == '0);
    inc_ign = ev[0] && (inc_lock_q != '0);
    dec_ign = ev[1] && (dec_lock_q != '0);

    // Simultaneous inc and dec cancel to the nominal step.
    step = CW'(1);
    if (inc_acc && !dec_acc) begin
      step = CW'(2);
    end else if (dec_acc && !inc_acc) begin
      step = '0;
    end

    sum   = cnt_q + step;
    cnt_d = sum;
    id_d  = id_q;
    if (sum >= DIV_C) begin
      cnt_d = sum - DIV_C;
      id_d  = ~id_q;
    end

    inc_lock_d = inc_lock_q;
    if (inc_acc) begin
      inc_lock_d = LOCK_LOAD;
    end else if (inc_lock_q != '0) begin
      inc_lock_d = inc_lock_q - LW'(1);
    end

    dec_lock_d = dec_lock_q;
    if (dec_acc) begin
      dec_lock_d = LOCK_LOAD;
    end else if (dec_lock_q != '0) begin
      dec_lock_d = dec_lock_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      inc_lock_q <= '0;
      dec_lock_q <= '0;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      inc_ign_q  <= 1'b0;
      dec_ign_q  <= 1'b0;
    end else begin
      prev_q     <= lvl_q;
      inc_lock_q <= inc_lock_d;
      dec_lock_q <= dec_lock_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      inc_q      <= inc_acc;
      dec_q      <= dec_acc;
      inc_ign_q  <= inc_ign;
      dec_ign_q  <= dec_ign;
    end
  end

  assign inc       = inc_q;
  assign dec       = dec_q;
  assign incIgnore = inc_ign_q;
  assign decIgnore = dec_ign_q;
  assign IDout     = id_q;

endmodule

// File: tb/tb_id_counter.sv
// tb/tb_id_counter.sv - directed self-checking bench for id_counter (DIV_HALF=2).
// Per-edge output vectors: bit k holds the value sampled just after edge k+1 following reset release.
module tb_id_counter;

  localparam int DIV_HALF = 2;
`ifdef IDC_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic incIn;
  logic decIn;
  logic inc;
  logic dec;
  logic incIgnore;
  logic decIgnore;
  logic IDout;

  id_counter #(.DIV_HALF(DIV_HALF)) dut (
    .clk       (clk),
    .reset     (reset),
    .incIn     (incIn),
    .decIn     (decIn),
    .inc       (inc),
    .dec       (dec),
    .incIgnore (incIgnore),
    .decIgnore (decIgnore),
    .IDout     (IDout)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] id_v, inc_v, dec_v, inci_v, deci_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic inc_lvl);
    reset = 1'b1;
    incIn = inc_lvl;
    decIn = 1'b0;
    repeat (2) @(posedge clk);
    #5 reset = 1'b0;
  endtask

  // Without the synchronizer the pipeline is one edge shorter, so stimulus is delayed one edge.
  task automatic run(input int n, input logic [15:0] ip, input logic [15:0] dp, input bit hold);
    if (!SYNC) begin
      ip = {ip[14:0], hold & ip[0]};
      dp = {dp[14:0], 1'b0};
    end
    id_v = '0; inc_v = '0; dec_v = '0; inci_v = '0; deci_v = '0;
    for (int k = 0; k < n; k++) begin
      incIn = ip[k];
      decIn = dp[k];
      @(posedge clk);
      #1;
      id_v[k]   = IDout;
      inc_v[k]  = inc;
      dec_v[k]  = dec;
      inci_v[k] = incIgnore;
      deci_v[k] = decIgnore;
      #4;
    end
    incIn = 1'b0;
    decIn = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_id, input logic [15:0] e_inc,
                           input logic [15:0] e_dec, input logic [15:0] e_inci, input logic [15:0] e_deci);
    check({tag, ".IDout"},     {16'h0, id_v},   {16'h0, e_id});
    check({tag, ".inc"},       {16'h0, inc_v},  {16'h0, e_inc});
    check({tag, ".dec"},       {16'h0, dec_v},  {16'h0, e_dec});
    check({tag, ".incIgnore"}, {16'h0, inci_v}, {16'h0, e_inci});
    check({tag, ".decIgnore"}, {16'h0, deci_v}, {16'h0, e_deci});
  endtask

  initial begin
    reset = 1'b1;
    incIn = 1'b0;
    decIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.IDout", {31'h0, IDout}, 32'h0);
    check("rst.pulses", {28'h0, inc, dec, incIgnore, decIgnore}, 32'h0);
    #4 reset = 1'b0;

    run(16, 16'h0000, 16'h0000, 1'b0);
    check_all("nominal", 16'h6666, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    do_reset(1'b0);
    run(16, 16'h0004, 16'h0000, 1'b0);
    check_all("inc1", 16'h3336, 16'h0010, 16'h0000, 16'h0000, 16'h0000);

    do_reset(1'b0);
    run(16, 16'h0000, 16'h0004, 1'b0);
    check_all("dec1", 16'hCCC6, 16'h0000, 16'h0010, 16'h0000, 16'h0000);

    do_reset(1'b0);
    run(16, 16'h0154, 16'h0000, 1'b0);
    check_all("inc_train", 16'h9936, 16'h0110, 16'h0000, 16'h0440, 16'h0000);

    do_reset(1'b0);
    run(16, 16'h0004, 16'h0004, 1'b0);
    check_all("both", 16'h6666, 16'h0010, 16'h0010, 16'h0000, 16'h0000);

    do_reset(1'b0);
    run(16, 16'h0010, 16'h0014, 1'b0);
    check_all("cross", 16'h6646, 16'h0040, 16'h0010, 16'h0000, 16'h0040);

    do_reset(1'b1);
    run(16, 16'hFFFF, 16'h0000, 1'b1);
    check_all("held", 16'h3332, SYNC ? 16'h0004 : 16'h0002, 16'h0000, 16'h0000, 16'h0000);

    // Reset mid-lockout while IDout is high must clear it without a clock edge.
    do_reset(1'b0);
    run(5, 16'h0004, 16'h0000, 1'b0);
    check("pre_rst.IDout", {16'h0, id_v}, 32'h0016);
    check("pre_rst.inc", {16'h0, inc_v}, 32'h0010);
    reset = 1'b1;
    #1;
    check("async_rst.IDout", {31'h0, IDout}, 32'h0);
    check("async_rst.inc", {31'h0, inc}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold.IDout", {31'h0, IDout}, 32'h0);
    #4 reset = 1'b0;
    run(8, 16'h0001, 16'h0000, 1'b0);
    check_all("post_rst", 16'h0032, 16'h0004, 16'h0000, 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
